instr_loader: RTL and testbench

//  Program loader directly upstream of the instruction memory. It takes a byte stream

---
 rtl/mips_loader_pkg.sv | 20 ++
 rtl/byte_assembler.sv | 40 ++++
 rtl/instr_loader.sv | 129 ++++++++++++
 tb/tb_instr_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_loader_pkg.sv
// Shared definitions for the program loader: FSM state encodings, the default
// end-of-program marker and the byte packing factor.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD    = 4;

  function automatic logic is_loading(input state_t s);
    return (s == ST_RECV) || (s == ST_WRITE) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs accepted bytes big-endian into a word; word_valid pulses combinationally
// with the 4th byte so the word can be registered on the same edge.
module byte_assembler
  import mips_loader_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [BYTE_WIDTH-1:0] rx_byte,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam int HOLD_W = DATA_WIDTH - BYTE_WIDTH;

  // Only the first three bytes are stored; the 4th is taken straight from rx_byte.
  logic [HOLD_W-1:0] hold;
  logic [1:0]        cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
      cnt  <= '0;
    end else if (clear) begin
      hold <= '0;
      cnt  <= '0;
    end else if (accept) begin
      hold <= {hold[HOLD_W-BYTE_WIDTH-1:0], rx_byte};
      cnt  <= cnt + 2'd1;
    end
  end

  assign word_valid = accept && (cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {hold, rx_byte};

endmodule

// File: rtl/instr_loader.sv
// Program loader: packs UART bytes into instruction words and writes them to
// consecutive instruction memory addresses until HALT or the memory is full.
// Optional trailer checksum enabled by defining LOADER_CHECKSUM_EN.
module instr_loader
  import mips_loader_pkg::*;
#(
  parameter int              DATA_WIDTH = 32,
  parameter int              ADDR_WIDTH = 32,
  parameter int              MEM_DEPTH  = 2048,
  parameter int              BYTE_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [BYTE_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_we,
  output logic                  o_mem_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [11:0]           o_word_count,
  output logic                  o_overflow,
  output logic                  o_chk_err
);

  state_t                state, state_nx;
  logic                  start_ok, accept, word_valid, is_halt, last_slot;
  logic [DATA_WIDTH-1:0] word;

  assign start_ok  = i_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign accept    = i_rx_valid && ((state == ST_RECV) || (state == ST_WRITE));
  assign is_halt   = (o_mem_data == HALT_WORD);
  assign last_slot = (o_mem_addr == ADDR_WIDTH'(MEM_DEPTH - 1));

  byte_assembler #(
    .BYTE_WIDTH (BYTE_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_asm (
    .clk        (i_clk),
    .rst        (i_rst),
    .clear      (start_ok),
    .accept     (accept),
    .rx_byte    (i_rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (i_start) state_nx = ST_RECV;
      ST_RECV:          if (word_valid) state_nx = ST_WRITE;
      ST_WRITE: begin
        if (is_halt)
`ifdef LOADER_CHECKSUM_EN
          state_nx = ST_CHECK;
`else
          state_nx = ST_DONE;
`endif
        else if (last_slot) state_nx = ST_DONE;
        else                state_nx = ST_RECV;
      end
      ST_CHECK:         if (i_rx_valid) state_nx = ST_DONE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    o_mem_we = 1'b0;
    o_mem_en = 1'b0;
    o_busy   = is_loading(state);
    o_done   = (state == ST_DONE);
    if (state == ST_WRITE) begin
      o_mem_we = 1'b1;
      o_mem_en = 1'b1;
    end
  end

  // o_mem_data keeps the last written word; address advances only after a write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      o_word_count <= '0;
      o_overflow   <= 1'b0;
    end else begin
      if (start_ok) begin
        o_mem_addr   <= '0;
        o_word_count <= '0;
        o_overflow   <= 1'b0;
      end
      if (word_valid) o_mem_data <= word;
      if (state == ST_WRITE) begin
        o_mem_addr <= o_mem_addr + ADDR_WIDTH'(1);
        if (o_word_count != 12'(MEM_DEPTH)) o_word_count <= o_word_count + 12'd1;
        if (!is_halt && last_slot) o_overflow <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] csum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      csum      <= '0;
      o_chk_err <= 1'b0;
    end else begin
      if (start_ok) begin
        csum      <= '0;
        o_chk_err <= 1'b0;
      end
      if (accept) csum <= csum ^ i_rx_data;
      if ((state == ST_CHECK) && i_rx_valid) o_chk_err <= (i_rx_data != csum);
    end
  end
`else
  assign o_chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a queue-based model of the expected memory
// writes is checked every cycle, plus literal end-of-load expectations.
`timescale 1ns/1ps
module tb_instr_loader;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, sel = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  always #5 clk = ~clk;

  logic [31:0] a_addr, a_data, b_addr, b_data;
  logic        a_we, a_en, a_busy, a_done, a_ovf, a_chk;
  logic        b_we, b_en, b_busy, b_done, b_ovf, b_chk;
  logic [11:0] a_cnt, b_cnt;

  instr_loader dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start & ~sel), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_mem_addr(a_addr), .o_mem_data(a_data), .o_mem_we(a_we), .o_mem_en(a_en), .o_busy(a_busy),
    .o_done(a_done), .o_word_count(a_cnt), .o_overflow(a_ovf), .o_chk_err(a_chk)
  );

  instr_loader #(.MEM_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start & sel), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_mem_addr(b_addr), .o_mem_data(b_data), .o_mem_we(b_we), .o_mem_en(b_en), .o_busy(b_busy),
    .o_done(b_done), .o_word_count(b_cnt), .o_overflow(b_ovf), .o_chk_err(b_chk)
  );

  int          checks = 0, errors = 0;
  logic [63:0] exp_a[$], exp_b[$];
  int          exp_cnt[2];
  logic        exp_ovf[2];
  logic [7:0]  exp_xor[2];
  bit          prev_we[2];
  logic [31:0] last_wr[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected writes from the byte stream: pack big-endian, stop at HALT or depth.
  task automatic plan(input int k, input bq_t b, input int depth);
    logic [31:0] w;
    int          n = 0;
    logic        o = 1'b0;
    logic [7:0]  x = 8'h00;
    for (int i = 0; i + 3 < b.size(); i += 4) begin
      w = {b[i], b[i+1], b[i+2], b[i+3]};
      x = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
      if (k == 0) exp_a.push_back({32'(n), w});
      else        exp_b.push_back({32'(n), w});
      n++;
      if (w == 32'hFFFF_FFFF) break;
      if (n == depth) begin o = 1'b1; break; end
    end
    exp_cnt[k] = n;
    exp_ovf[k] = o;
    exp_xor[k] = x;
  endtask

  task automatic cmp_port(input int k, input logic we, input logic en, input logic [31:0] addr,
                          input logic [31:0] data, input logic chk);
    logic [63:0] e;
    int          qs;
    check($sformatf("en_eq_we%0d", k), en, we);
    if (we) begin
      check($sformatf("we_one_cycle%0d", k), prev_we[k], 1'b0);
      qs = (k == 0) ? exp_a.size() : exp_b.size();
      if (qs == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write%0d: got addr %0h data %0h expected no write", k, addr, data);
      end else begin
        if (k == 0) e = exp_a.pop_front();
        else        e = exp_b.pop_front();
        check($sformatf("write%0d", k), {addr, data}, e);
        last_wr[k] = data;
      end
    end
    prev_we[k] = we;
`ifndef LOADER_CHECKSUM_EN
    check($sformatf("chk_err_off%0d", k), chk, 1'b0);
`endif
  endtask

  always @(negedge clk) begin
    cmp_port(0, a_we, a_en, a_addr, a_data, a_chk);
    cmp_port(1, b_we, b_en, b_addr, b_data, b_chk);
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", {a_addr, a_data, a_we, a_en, a_busy, a_done, a_ovf, a_chk, a_cnt}, '0);
    check("reset_b", {b_addr, b_data, b_we, b_en, b_busy, b_done, b_ovf, b_chk, b_cnt}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic s);
    sel = s; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // spaced: one idle cycle after bytes 1-3 of a word, none after the 4th (lands in WRITE).
  task automatic send(input bq_t b, input bit spaced);
    foreach (b[i]) begin
      rx_data = b[i]; rx_valid = 1'b1;
      @(posedge clk); #1 rx_valid = 1'b0;
      if (spaced && (i % 4 != 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input int k);
    int t = 0;
    while (!((k == 0) ? a_done : b_done) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check($sformatf("done_reached%0d", k), (k == 0) ? a_done : b_done, 1'b1);
  endtask

  task automatic finish_load(input int k);
`ifdef LOADER_CHECKSUM_EN
    if (!exp_ovf[k]) send('{exp_xor[k]}, 1'b0);
`endif
    wait_done(k);
  endtask

  task automatic end_check(input int k, input string tag);
    check({tag, "_busy"},  (k == 0) ? a_busy : b_busy, 1'b0);
    check({tag, "_count"}, (k == 0) ? a_cnt : b_cnt, 64'(exp_cnt[k]));
    check({tag, "_ovf"},   (k == 0) ? a_ovf : b_ovf, exp_ovf[k]);
    check({tag, "_addr"},  (k == 0) ? a_addr : b_addr, 64'(exp_cnt[k]));
    check({tag, "_chk"},   (k == 0) ? a_chk : b_chk, 1'b0);
    check({tag, "_pending"}, (k == 0) ? exp_a.size() : exp_b.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t t1, t2, t3, t4, pre;
    t1  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    t2  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    t3  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
    t4  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hAA, 8'hBB};
    pre = '{8'h77, 8'h88};

    do_reset();

    // 1: basic two-word program
    pulse_start(1'b0);
    plan(0, t1, 2048);
    check("t1_model_word0", exp_a[0], {32'd0, 32'h0001_0203});
    check("t1_model_xor", exp_xor[0], 8'h00);
    send(t1, 1'b0);
    finish_load(0);
    end_check(0, "t1");
    check("t1_count_lit", a_cnt, 12'd2);
    check("t1_last_word", last_wr[0], 32'hFFFF_FFFF);

    // 2: spaced bytes, first byte of each new word lands in WRITE
    pulse_start(1'b0);
    plan(0, t2, 2048);
    send(t2, 1'b1);
    finish_load(0);
    end_check(0, "t2");
    check("t2_count_lit", a_cnt, 12'd3);

    // 3: small memory fills without HALT; extra bytes in DONE are ignored
    pulse_start(1'b1);
    plan(1, t3, 4);
    send(t3, 1'b0);
    wait_done(1);
    end_check(1, "t3");
    check("t3_ovf_lit", b_ovf, 1'b1);
    send('{8'h10, 8'h20, 8'h30, 8'h40}, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_count_hold", b_cnt, 12'd4);
    check("t3_done_hold", b_done, 1'b1);
    sel = 1'b0;

    // 4: reset two bytes into word 3, then reload
    pulse_start(1'b0);
    plan(0, t4, 2048);
    send(t4, 1'b0);
    check("t4_busy_mid", a_busy, 1'b1);
    check("t4_written", exp_a.size(), 0);
    do_reset();
    pulse_start(1'b0);
    plan(0, t1, 2048);
    send(t1, 1'b0);
    finish_load(0);
    end_check(0, "t4");

    // 5: bytes before start and a start pulse mid-load are ignored
    do_reset();
    send(pre, 1'b0);
    check("t5_idle_addr", a_addr, 32'd0);
    pulse_start(1'b0);
    plan(0, t1, 2048);
    send(t1[0:1], 1'b0);
    pulse_start(1'b0);
    send(t1[2:7], 1'b0);
    finish_load(0);
    end_check(0, "t5");
    check("t5_count_lit", a_cnt, 12'd2);

`ifdef LOADER_CHECKSUM_EN
    // 6: good and bad trailers
    pulse_start(1'b0);
    plan(0, t1, 2048);
    send(t1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_in_check", a_busy, 1'b1);
    send('{8'h00}, 1'b0);
    wait_done(0);
    check("t6_good_trailer", a_chk, 1'b0);
    pulse_start(1'b0);
    plan(0, t1, 2048);
    send(t1, 1'b0);
    send('{8'h5A}, 1'b0);
    wait_done(0);
    check("t6_bad_trailer", a_chk, 1'b1);
`else
    // 6: without the checksum a trailer byte after DONE changes nothing
    send('{8'h5A}, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_trailer_done", a_done, 1'b1);
    check("t6_trailer_count", a_cnt, 12'd2);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
